// File: rtl/ring_node_top.sv
// Distributed-simulation partition node: periodic LFSR events feed a FIFO that drains onto the ring.
// Identity, time and statistics are read by the wrapper through the Frng_if sub-instance.

module ring_node_if #(
  parameter string NODE_NAME = "top_rtl",
  parameter int    CNT_W     = 32
) (
  input logic [CNT_W-1:0] time_cnt,
  input logic [CNT_W-1:0] evt_cnt,
  input logic [CNT_W-1:0] drop_cnt,
  input logic [CNT_W-1:0] sent_cnt,
  input logic [31:0]      csum
);

  // Pure combinational reads of the node's current register values.
  function automatic string who_iam();
    return NODE_NAME;
  endfunction

  function automatic logic [CNT_W-1:0] get_time();
    return time_cnt;
  endfunction

  function automatic logic [CNT_W-1:0] get_evt_cnt();
    return evt_cnt;
  endfunction

  function automatic logic [CNT_W-1:0] get_drop_cnt();
    return drop_cnt;
  endfunction

  function automatic logic [CNT_W-1:0] get_sent_cnt();
    return sent_cnt;
  endfunction

  function automatic logic [31:0] get_csum();
    return csum;
  endfunction

endmodule

module ring_node_top #(
  parameter string       NODE_NAME  = "top_rtl",
  parameter int          CNT_W      = 32,
  parameter int          EVT_PERIOD = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input logic i_clk,
  input logic reset_n
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PER_W = (EVT_PERIOD > 1) ? $clog2(EVT_PERIOD) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   FILL_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FILL_MAX = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(EVT_PERIOD - 1);
  localparam logic [15:0]      LFSR_MASK = 16'hB400;

  logic [CNT_W-1:0] time_cnt;
  logic [CNT_W-1:0] evt_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] sent_cnt;
  logic [31:0]      csum;
  logic [PER_W-1:0] per_cnt;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             pace;
  logic [15:0]      lfsr;
  logic [31:0]      mem [FIFO_DEPTH];

  logic        evt;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [15:0] lfsr_next;
  logic [15:0] time_lo;
  logic [31:0] payload;
  logic [31:0] pop_word;

  // FIFO handshake: the generator offers a word when evt is high and it is accepted
  // (push) only if a slot is free this cycle, counting a slot freed by a same-cycle pop;
  // an unaccepted offer is lost and counted as a drop. The ring side takes a word
  // (pop) whenever the pace slot is open and the FIFO holds data; it never stalls.
  always_comb begin
    evt       = (per_cnt == PER_LAST);
    full      = (count == FILL_MAX);
    empty     = (count == '0);
    pop       = pace && !empty;
    push      = evt && (!full || pop);
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    time_lo   = 16'(time_cnt);
    payload   = {time_lo, lfsr};
    pop_word  = mem[rd_ptr];
  end

  always_ff @(posedge i_clk) begin
    if (reset_n) begin
      time_cnt <= '0;
      evt_cnt  <= '0;
      drop_cnt <= '0;
      sent_cnt <= '0;
      csum     <= '0;
      per_cnt  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pace     <= 1'b0;
      lfsr     <= SEED;
    end else begin
      time_cnt <= time_cnt + CNT_ONE;
      lfsr     <= lfsr_next;
      per_cnt  <= evt ? '0 : per_cnt + PER_ONE;
      pace     <= ~pace;
      if (evt) evt_cnt <= evt_cnt + CNT_ONE;
      if (evt && !push) drop_cnt <= drop_cnt + CNT_ONE;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        sent_cnt <= sent_cnt + CNT_ONE;
        csum     <= csum ^ pop_word;
      end
      case ({push, pop})
        2'b10:   count <= count + FILL_ONE;
        2'b01:   count <= count - FILL_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge i_clk) begin
    if (!reset_n && push) mem[wr_ptr] <= payload;
  end

  ring_node_if #(
    .NODE_NAME(NODE_NAME),
    .CNT_W    (CNT_W)
  ) Frng_if (
    .time_cnt(time_cnt),
    .evt_cnt (evt_cnt),
    .drop_cnt(drop_cnt),
    .sent_cnt(sent_cnt),
    .csum    (csum)
  );

endmodule

// File: tb/tb_ring_node_top.sv
// Bench for ring_node_top: two configurations run side by side against a cycle-count based
// reference model with a queue standing in for the event FIFO.

module tb_ring_node_top;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ring_node_top dut0 (
    .i_clk  (clk),
    .reset_n(rst)
  );

  ring_node_top #(
    .CNT_W     (8),
    .EVT_PERIOD(1),
    .FIFO_DEPTH(8)
  ) dut1 (
    .i_clk  (clk),
    .reset_n(rst)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int          per   [2] = '{4, 1};
  int          depth [2] = '{8, 8};
  int unsigned mask  [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};

  // Reference state: k counts cycles since reset release, everything else follows from it.
  int unsigned k      [2];
  int unsigned m_evt  [2];
  int unsigned m_drop [2];
  int unsigned m_sent [2];
  logic [31:0] m_csum [2];
  logic [15:0] m_lfsr [2];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  bit          saw_full = 1'b0;

  function automatic logic [15:0] lfsr_step(logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      k[i]      = 0;
      m_evt[i]  = 0;
      m_drop[i] = 0;
      m_sent[i] = 0;
      m_csum[i] = '0;
      m_lfsr[i] = 16'hACE1;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_step(int i);
    int          sz;
    bit          evt, pop, push;
    logic [31:0] tm, word;
    sz   = (i == 0) ? exp_q0.size() : exp_q1.size();
    evt  = ((k[i] % per[i]) == per[i] - 1);
    pop  = ((k[i] % 2) == 1) && (sz > 0);
    push = evt && ((sz < depth[i]) || pop);
    tm   = k[i] & mask[i];
    word = {tm[15:0], m_lfsr[i]};
    if (pop) begin
      if (i == 0) m_csum[i] = m_csum[i] ^ exp_q0.pop_front();
      else        m_csum[i] = m_csum[i] ^ exp_q1.pop_front();
      m_sent[i]++;
    end
    if (push) begin
      if (i == 0) exp_q0.push_back(word);
      else        exp_q1.push_back(word);
    end else if (evt) begin
      m_drop[i]++;
    end
    if (evt) m_evt[i]++;
    k[i]++;
    m_lfsr[i] = lfsr_step(m_lfsr[i]);
  endtask

  task automatic check_dut0();
    logic [31:0] inv;
    chk("d0_time", 64'(dut0.Frng_if.get_time()),     64'(k[0] & mask[0]));
    chk("d0_evt",  64'(dut0.Frng_if.get_evt_cnt()),  64'(m_evt[0] & mask[0]));
    chk("d0_drop", 64'(dut0.Frng_if.get_drop_cnt()), 64'(m_drop[0] & mask[0]));
    chk("d0_sent", 64'(dut0.Frng_if.get_sent_cnt()), 64'(m_sent[0] & mask[0]));
    chk("d0_csum", 64'(dut0.Frng_if.get_csum()),     64'(m_csum[0]));
    chk("d0_count", 64'(dut0.count),                 64'(exp_q0.size()));
    chk("d0_lfsr", 64'(dut0.lfsr),                   64'(m_lfsr[0]));
    inv = 32'(dut0.Frng_if.get_sent_cnt()) + 32'(dut0.Frng_if.get_drop_cnt()) + 32'(dut0.count);
    chk("d0_invariant", 64'(dut0.Frng_if.get_evt_cnt()), 64'(inv & mask[0]));
  endtask

  task automatic check_dut1();
    logic [31:0] inv;
    chk("d1_time", 64'(dut1.Frng_if.get_time()),     64'(k[1] & mask[1]));
    chk("d1_evt",  64'(dut1.Frng_if.get_evt_cnt()),  64'(m_evt[1] & mask[1]));
    chk("d1_drop", 64'(dut1.Frng_if.get_drop_cnt()), 64'(m_drop[1] & mask[1]));
    chk("d1_sent", 64'(dut1.Frng_if.get_sent_cnt()), 64'(m_sent[1] & mask[1]));
    chk("d1_csum", 64'(dut1.Frng_if.get_csum()),     64'(m_csum[1]));
    chk("d1_count", 64'(dut1.count),                 64'(exp_q1.size()));
    chk("d1_lfsr", 64'(dut1.lfsr),                   64'(m_lfsr[1]));
    inv = 32'(dut1.Frng_if.get_sent_cnt()) + 32'(dut1.Frng_if.get_drop_cnt()) + 32'(dut1.count);
    chk("d1_invariant", 64'(dut1.Frng_if.get_evt_cnt()), 64'(inv & mask[1]));
    if (dut1.count == 4'd8) saw_full = 1'b1;
  endtask

  // One clock: the model follows the reset level the DUT samples, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    check_dut0();
    check_dut1();
  endtask

  initial begin
    logic [15:0] l3;
    int          n_run, n_rst;
    l3 = lfsr_step(lfsr_step(lfsr_step(16'hACE1)));

    // Reset held for five cycles.
    rst = 1'b1;
    repeat (5) tick();
    chk("rst_d0_time", 64'(dut0.Frng_if.get_time()), 64'd0);
    chk("rst_d0_empty", 64'(dut0.empty), 64'd1);
    chk("rst_d0_lfsr", 64'(dut0.lfsr), 64'hACE1);

    rst = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 6) begin
        chk("first_pop_sent", 64'(dut0.Frng_if.get_sent_cnt()), 64'd1);
        chk("first_pop_csum", 64'(dut0.Frng_if.get_csum()), 64'({16'd3, l3}));
      end
      if (c <= 40) chk("d0_count_le1", 64'(dut0.count <= 4'd1), 64'd1);
      if (c == 40) begin
        chk("d0_evt_40", 64'(dut0.Frng_if.get_evt_cnt()), 64'd10);
        chk("d0_drop_40", 64'(dut0.Frng_if.get_drop_cnt()), 64'd0);
        chk("d1_reached_full", 64'(saw_full), 64'd1);
        chk("d1_dropped", 64'(dut1.Frng_if.get_drop_cnt() != 8'd0), 64'd1);
      end
    end
    chk("d0_time_60", 64'(dut0.Frng_if.get_time()), 64'd60);
    n_cmp++;
    assert (dut0.Frng_if.who_iam() == "top_rtl") else begin
      n_fail++;
      $error("FAIL who_iam observed=%s expected=top_rtl", dut0.Frng_if.who_iam());
    end

    // Mid-run reset with the FIFO holding data.
    chk("d1_nonempty_pre_reset", 64'(dut1.count != 4'd0), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_d1_empty", 64'(dut1.empty), 64'd1);
    chk("mid_rst_d1_lfsr", 64'(dut1.lfsr), 64'hACE1);
    chk("mid_rst_d1_evt", 64'(dut1.Frng_if.get_evt_cnt()), 64'd0);
    chk("mid_rst_d1_csum", 64'(dut1.Frng_if.get_csum()), 64'd0);
    rst = 1'b0;

    // Long run so the 8-bit counters of the second node wrap.
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (c == 255) chk("d1_time_max", 64'(dut1.Frng_if.get_time()), 64'hFF);
      if (c == 256) begin
        chk("d1_time_wrap", 64'(dut1.Frng_if.get_time()), 64'd0);
        chk("d0_time_nowrap", 64'(dut0.Frng_if.get_time()), 64'd256);
      end
    end

    // Random run lengths interleaved with random-length resets.
    for (int r = 0; r < 8; r++) begin
      n_run = $urandom_range(80, 3);
      n_rst = $urandom_range(3, 1);
      repeat (n_run) tick();
      rst = 1'b1;
      repeat (n_rst) tick();
      rst = 1'b0;
    end
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
